// File: rtl/ama_riscv_fetch_pkg.sv
// AMA-RISCV fetch shared definitions.
// Next-PC selects and bubble instruction, shared with the decoder.
package ama_riscv_fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEL_INC4       = 2'd0,
    PC_SEL_ALU        = 2'd1,
    PC_SEL_BP         = 2'd2,
    PC_SEL_START_ADDR = 2'd3
  } pc_sel_e;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

endpackage

// File: rtl/ama_riscv_reset_seq.sv
// Post-reset pipeline-clear sequencer: 111 -> 110 -> 100 -> 000.
// Ports: clk, rst (async high) in; clear_rst_id/ex/mem out.
module ama_riscv_reset_seq (
  input  logic clk,
  input  logic rst,
  output logic clear_rst_id,
  output logic clear_rst_ex,
  output logic clear_rst_mem
);

  logic [2:0] rst_seq_q;
  logic [2:0] rst_seq_d;

  always_comb begin
    rst_seq_d = {rst_seq_q[1:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_seq_q <= 3'b111;
    else     rst_seq_q <= rst_seq_d;
  end

  assign clear_rst_id  = rst_seq_q[0];
  assign clear_rst_ex  = rst_seq_q[1];
  assign clear_rst_mem = rst_seq_q[2];

endmodule

// File: rtl/ama_riscv_fetch.sv
// AMA-RISCV IF stage and IF/ID boundary: PC, next-PC, IMEM drive.
// Ports: decoder ctrl in, IMEM en/addr/rdata, inst/pc/valid to ID.
module ama_riscv_fetch
  import ama_riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_AW      = 14,
  parameter logic [31:0] NOP_INST     = NOP_INST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel,
  input  logic [1:0]         pc_we,
  input  logic               stall_if,
  input  logic               clear_if,
  input  logic [31:0]        alu_out,
  input  logic [31:0]        bp_target,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        inst_id,
  output logic [31:0]        pc_id,
  output logic               inst_valid_id,
  output logic               clear_rst_id,
  output logic               clear_rst_ex,
  output logic               clear_rst_mem
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        bub_q, bub_d;
  logic [31:0] nxt;
  logic        first;
  logic        hold;
  logic        unused;

  ama_riscv_reset_seq u_rst_seq (
    .clk           (clk),
    .rst           (rst),
    .clear_rst_id  (clear_rst_id),
    .clear_rst_ex  (clear_rst_ex),
    .clear_rst_mem (clear_rst_mem)
  );

  // First cycle after reset ignores all decoder control.
  assign first = clear_rst_id;

  always_comb begin
    nxt = pc_q + 32'd4;
    unique case (pc_sel_e'(pc_sel))
      PC_SEL_INC4:       nxt = pc_q + 32'd4;
      PC_SEL_ALU:        nxt = {alu_out[31:2], 2'b00};
      PC_SEL_BP:         nxt = {bp_target[31:2], 2'b00};
      PC_SEL_START_ADDR: nxt = RESET_VECTOR;
      default:           nxt = pc_q + 32'd4;
    endcase
  end

  always_comb begin
    hold    = ~first & (stall_if | (pc_we == 2'b00));
    pc_d    = pc_q;
    pc_id_d = pc_id_q;
    bub_d   = bub_q | clear_if;
    if (first) begin
      pc_d    = RESET_VECTOR + 32'd4;
      pc_id_d = RESET_VECTOR;
      bub_d   = 1'b0;
    end else if (!hold) begin
      pc_d    = nxt;
      pc_id_d = pc_q;
      bub_d   = clear_if;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      pc_id_q <= RESET_VECTOR;
      bub_q   <= 1'b1;
    end else begin
      pc_q    <= pc_d;
      pc_id_q <= pc_id_d;
      bub_q   <= bub_d;
    end
  end

  assign imem_en       = ~rst & ~hold;
  assign imem_addr     = pc_q[IMEM_AW+1:2];
  assign inst_id       = bub_q ? NOP_INST : imem_rdata;
  assign inst_valid_id = ~bub_q;
  assign pc_id         = pc_id_q;

  assign unused = ^{alu_out[1:0], bp_target[1:0],
                    pc_q[31:IMEM_AW+2], pc_q[1:0]};

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Self-checking bench for ama_riscv_fetch.
// Directed plan steps then random control vs. a transaction model.
module tb_ama_riscv_fetch;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [1:0]  pc_we;
  logic        stall_if;
  logic        clear_if;
  logic [31:0] alu_out;
  logic [31:0] bp_target;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        inst_valid_id;
  logic        clear_rst_id;
  logic        clear_rst_ex;
  logic        clear_rst_mem;

  logic [31:0] mem [0:16383];

  int n_assert = 0;
  int n_fail   = 0;

  // transaction-level model state
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_valid;
  int          m_cnt;

  always #5 clk = ~clk;

  ama_riscv_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .pc_sel        (pc_sel),
    .pc_we         (pc_we),
    .stall_if      (stall_if),
    .clear_if      (clear_if),
    .alu_out       (alu_out),
    .bp_target     (bp_target),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .inst_id       (inst_id),
    .pc_id         (pc_id),
    .inst_valid_id (inst_valid_id),
    .clear_rst_id  (clear_rst_id),
    .clear_rst_ex  (clear_rst_ex),
    .clear_rst_mem (clear_rst_mem)
  );

  // synchronous-read IMEM, output holds while disabled
  always_ff @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] word(input logic [31:0] a);
    return a[15:2];
  endfunction

  task automatic m_reset();
    m_pc       = RV;
    m_id_pc    = RV;
    m_id_inst  = NOP;
    m_id_valid = 1'b0;
    m_cnt      = 0;
  endtask

  task automatic chk_clears(input string tag);
    chk({tag, "_clr_id"}, 32'(clear_rst_id), 32'(m_cnt < 1));
    chk({tag, "_clr_ex"}, 32'(clear_rst_ex), 32'(m_cnt < 2));
    chk({tag, "_clr_mem"}, 32'(clear_rst_mem), 32'(m_cnt < 3));
  endtask

  task automatic chk_id(input string tag);
    chk({tag, "_inst"}, inst_id, m_id_valid ? m_id_inst : NOP);
    chk({tag, "_pc_id"}, pc_id, m_id_pc);
    chk({tag, "_valid"}, 32'(inst_valid_id), 32'(m_id_valid));
  endtask

  // One clock: check IF-side outputs, advance model, check ID side.
  task automatic cyc(input string tag);
    logic hold;
    logic [31:0] tgt;
    #1;
    hold = (m_cnt > 0) && (stall_if || pc_we == 2'b00);
    chk({tag, "_en"}, 32'(imem_en), 32'(!hold));
    chk({tag, "_addr"}, 32'(imem_addr), 32'(word(m_pc)));
    case (pc_sel)
      2'd0:    tgt = m_pc + 32'd4;
      2'd1:    tgt = alu_out & ~32'd3;
      2'd2:    tgt = bp_target & ~32'd3;
      default: tgt = RV;
    endcase
    if (m_cnt == 0) begin
      m_id_inst  = mem[word(m_pc)];
      m_id_pc    = m_pc;
      m_id_valid = 1'b1;
      m_pc       = RV + 32'd4;
    end else if (hold) begin
      m_id_valid = m_id_valid && !clear_if;
    end else begin
      m_id_inst  = mem[word(m_pc)];
      m_id_pc    = m_pc;
      m_id_valid = !clear_if;
      m_pc       = tgt;
    end
    if (m_cnt < 3) m_cnt++;
    @(posedge clk);
    #1;
    chk_id(tag);
    chk_clears(tag);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    rst = 1'b1;
    pc_sel = 2'd0;
    pc_we = 2'd1;
    stall_if = 1'b0;
    clear_if = 1'b0;
    alu_out = 32'h0;
    bp_target = 32'h0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_en", 32'(imem_en), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk_id("rst");
    chk_clears("rst");
    @(negedge clk);
    rst = 1'b0;

    // 1: reset release
    cyc("t1_e1");
    chk("t1_e1_lit_inst", inst_id, 32'h0050_0093);
    chk("t1_e1_lit_pc", pc_id, 32'h0);
    cyc("t1_e2");
    chk("t1_e2_lit_inst", inst_id, 32'h00A0_0113);
    chk("t1_e2_lit_pc", pc_id, 32'h4);

    // 2: stall with pc=8
    stall_if = 1'b1;
    cyc("t2_s1");
    cyc("t2_s2");
    chk("t2_hold_pc", pc_id, 32'h4);
    stall_if = 1'b0;
    cyc("t2_rel");
    chk("t2_rel_inst", inst_id, mem[2]);
    chk("t2_rel_pc", pc_id, 32'h8);

    // 3: redirect from pc=0x10 with clear
    cyc("t3_pre");
    pc_sel = 2'd1;
    alu_out = 32'h40;
    clear_if = 1'b1;
    cyc("t3_clr");
    chk("t3_nop", inst_id, NOP);
    chk("t3_nop_pc", pc_id, 32'h10);
    pc_sel = 2'd0;
    clear_if = 1'b0;
    cyc("t3_tgt");
    chk("t3_tgt_inst", inst_id, mem[16]);
    chk("t3_tgt_pc", pc_id, 32'h40);

    // 4: branch prediction target alignment
    pc_sel = 2'd2;
    bp_target = 32'h0000_0103;
    cyc("t4_bp");
    pc_sel = 2'd0;
    #1;
    chk("t4_addr", 32'(imem_addr), 32'h40);

    // 5: PC wrap and pc_we=0
    pc_sel = 2'd1;
    alu_out = 32'hFFFF_FFFF;
    cyc("t5_jmp");
    pc_sel = 2'd0;
    #1;
    chk("t5_top_addr", 32'(imem_addr), 32'h3FFF);
    cyc("t5_wrap");
    chk("t5_wrap_addr", 32'(imem_addr), 32'h0);
    pc_we = 2'd0;
    cyc("t5_we0");
    chk("t5_we0_addr", 32'(imem_addr), 32'h0);
    pc_we = 2'd1;

    // 6: async reset mid-operation
    pc_sel = 2'd1;
    alu_out = 32'h20;
    cyc("t6_pre");
    pc_sel = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("t6_en", 32'(imem_en), 32'd0);
    chk("t6_addr", 32'(imem_addr), 32'(word(RV)));
    chk_id("t6");
    chk_clears("t6");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc("t6_seq");

    // random control traffic
    for (int i = 0; i < 400; i++) begin
      pc_sel    = 2'($urandom_range(0, 3));
      pc_we     = 2'($urandom_range(0, 3));
      stall_if  = ($urandom_range(0, 4) == 0);
      clear_if  = ($urandom_range(0, 5) == 0);
      alu_out   = $urandom;
      bp_target = $urandom;
      if ($urandom_range(0, 1) == 0) pc_sel = 2'd0;
      cyc("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
